id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for a classic 5-stage RISC pipeline. It captures the
// decoded instruction fields, decodes the 3-bit ALU control word, picks the
// write-back register, and selects the ALU operands (optionally forwarded from
// the EX/MEM and MEM/WB stages).
//
// Configuration macro:
//   ID_EX_FORWARD_EN  defined   -> EX/MEM and MEM/WB operand forwarding enabled
//                     undefined -> operands come only from the registered values
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   stall, flush               hold contents / insert a bubble
//   id_*                       decoded fields from the ID stage
//   exmem_*, memwb_*           forwarding sources (write enable, rd, result)
//   alu_dataA, alu_dataB       ALU operands
//   alu_signal                 ALU control (010 add, 110 sub, 000 and,
//                              001 or, 111 slt)
//   ex_valid, ex_reg_write     stage valid, gated register write enable
//   ex_wr_reg                  destination register number
//   ex_store_data              forwarded rt value for stores
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             exmem_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_dataA,
  output logic [WIDTH-1:0] alu_dataB,
  output logic [2:0]       alu_signal,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic [4:0]       ex_wr_reg,
  output logic [WIDTH-1:0] ex_store_data
);

  logic             valid_reg;
  logic             reg_write_reg;
  logic [4:0]       wr_reg_reg;
  logic [2:0]       alu_signal_reg;
  logic [2:0]       alu_signal_next;
  logic [WIDTH-1:0] rs_data_reg;
  logic [WIDTH-1:0] rt_data_reg;
  logic [WIDTH-1:0] imm_reg;
  logic [4:0]       rs_reg;
  logic [4:0]       rt_reg;
  logic             alu_src_reg;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  // ALU control decode, done before the register so EX sees a ready code.
  always_comb begin
    alu_signal_next = 3'b010;
    case (id_alu_op)
      2'b00: alu_signal_next = 3'b010;
      2'b01: alu_signal_next = 3'b110;
      2'b10: begin
        case (id_funct)
          6'b100000: alu_signal_next = 3'b010;
          6'b100010: alu_signal_next = 3'b110;
          6'b100100: alu_signal_next = 3'b000;
          6'b100101: alu_signal_next = 3'b001;
          6'b101010: alu_signal_next = 3'b111;
          default:   alu_signal_next = 3'b010;
        endcase
      end
      default: alu_signal_next = 3'b010;
    endcase
  end

  // Reset and flush load the same all-zero bubble; reset simply wins first.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_reg      <= 1'b0;
      reg_write_reg  <= 1'b0;
      wr_reg_reg     <= 5'd0;
      alu_signal_reg <= 3'b000;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
      rs_reg         <= 5'd0;
      rt_reg         <= 5'd0;
      alu_src_reg    <= 1'b0;
    end else if (!stall) begin
      valid_reg      <= id_valid;
      reg_write_reg  <= id_reg_write;
      wr_reg_reg     <= id_reg_dst ? id_rd : id_rt;
      alu_signal_reg <= alu_signal_next;
      rs_data_reg    <= id_rs_data;
      rt_data_reg    <= id_rt_data;
      imm_reg        <= id_imm;
      rs_reg         <= id_rs;
      rt_reg         <= id_rt;
      alu_src_reg    <= id_alu_src;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // The younger EX/MEM result takes precedence over MEM/WB; r0 is hardwired
  // zero in the register file, so it is never a forwarding target.
  always_comb begin
    fwd_a = rs_data_reg;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_reg))
      fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_reg))
      fwd_a = memwb_result;
  end

  always_comb begin
    fwd_b = rt_data_reg;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_reg))
      fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_reg))
      fwd_b = memwb_result;
  end
`else
  assign fwd_a = rs_data_reg;
  assign fwd_b = rt_data_reg;

  // Forwarding sources and register numbers have no consumer in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result,
                        rs_reg, rt_reg};
`endif

  assign alu_dataA     = fwd_a;
  assign alu_dataB     = alu_src_reg ? imm_reg : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_signal    = alu_signal_reg;
  assign ex_valid      = valid_reg;
  assign ex_reg_write  = valid_reg & reg_write_reg;
  assign ex_wr_reg     = wr_reg_reg;

endmodule
